// File: rtl/gate_sweep_defs.sv
// Shared encodings and constants for the gate sweep sequencer.
// Optional first-failure log: GATE_SWEEP_ERRLOG_EN.
package gate_sweep_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;

  localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_sweep_timer.sv
// Dwell down-counter; last flags the final cycle of a vector.
// Reload is driven by the controller on each vector boundary.
module gate_sweep_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Steps a two-input gate through 00..11 and checks it against a truth table.
// Define GATE_SWEEP_ERRLOG_EN to capture the first failing vector.
module gate_sweep_ctrl
  import gate_sweep_defs::*;
#(
  parameter int DWELL_W = 8,
  parameter int ERR_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         expect_tt,
  input  logic               gate_out,
  output logic               input1,
  output logic               input2,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [1:0]         fail_vec,
  output logic               fail_valid
);

  state_t state, state_nx;

  logic               accept;
  logic               step;
  logic               last;
  logic               mismatch;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] tmr_value;
  logic [3:0]         tt_q;
  logic [1:0]         vec;
  logic [ERR_W-1:0]   err_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last && vec == LAST_VEC) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && start;
  assign step      = (state == RUN) && last;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign tmr_value = accept ? dwell_eff : dwell_q;

  gate_sweep_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (accept | step),
    .value (tmr_value),
    .enable(state == RUN),
    .last  (last)
  );

  assign mismatch = (gate_out != tt_q[vec]);
  assign err_nx   = (mismatch && err_count != '1)
                  ? err_count + 1'b1
                  : err_count;

  // vec is the registered gate drive; it returns to 00 on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q   <= '0;
      tt_q      <= '0;
      vec       <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      dwell_q   <= dwell_eff;
      tt_q      <= expect_tt;
      vec       <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (step) begin
      err_count <= err_nx;
      if (vec == LAST_VEC) begin
        vec  <= '0;
        pass <= (err_nx == '0);
      end else begin
        vec <= vec + 1'b1;
      end
    end
  end

  assign input1 = vec[1];
  assign input2 = vec[0];

`ifdef GATE_SWEEP_ERRLOG_EN
  logic [1:0] fvec_q;
  logic       fvalid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else if (accept) begin
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else if (step && mismatch && !fvalid_q) begin
      fvec_q   <= vec;
      fvalid_q <= 1'b1;
    end
  end

  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;
`else
  assign fail_vec   = 2'b00;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl with a behavioural gate on gate_out.
// Expected results are queued at start; a monitor checks on done.
module tb_gate_sweep_ctrl;
  import gate_sweep_defs::*;

  localparam int DW = 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    expect_tt = '0;
  logic          gate_out;
  logic          input1, input2;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [1:0]    fail_vec;
  logic          fail_valid;

  int mode = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  int exp_dones = 0;

  typedef struct {
    int         s;
    int         d;
    logic       p;
    int         e;
    logic       fv;
    logic [1:0] fvec;
  } exp_t;

  exp_t q[$];

  gate_sweep_ctrl #(
    .DWELL_W(DW),
    .ERR_W  (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dwell     (dwell),
    .expect_tt (expect_tt),
    .gate_out  (gate_out),
    .input1    (input1),
    .input2    (input2),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    gate_out = 1'b0;
    case (mode)
      0: gate_out = input1 | input2;
      1: gate_out = input1 & input2;
      2: gate_out = 1'b0;
      default: gate_out = ~(input1 & input2);
    endcase
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   k;
    if (!reset) begin
      if (q.size() > 0 && busy) begin
        k = (cyc - q[0].s) / q[0].d;
        chk("vector", int'({input1, input2}), k);
      end
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.s + 1, 4 * e.d + 1);
          chk("done_inputs", int'({input1, input2}), 0);
          chk("pass", int'(pass), int'(e.p));
          chk("err_count", int'(err_count), e.e);
          chk("fail_valid", int'(fail_valid), int'(e.fv));
          chk("fail_vec", int'(fail_vec), int'(e.fvec));
        end
      end
    end
  end

  task automatic launch(input int d, input logic [3:0] tt,
                        input int m, input logic p, input int e,
                        input logic fv, input logic [1:0] fvec);
    exp_t x;
    @(negedge clk);
    mode      = m;
    dwell     = DW'(d);
    expect_tt = tt;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    x.s    = cyc;
    x.d    = (d == 0) ? 1 : d;
    x.p    = p;
    x.e    = e;
`ifdef GATE_SWEEP_ERRLOG_EN
    x.fv   = fv;
    x.fvec = fvec;
`else
    x.fv   = 1'b0;
    x.fvec = 2'b00;
`endif
    q.push_back(x);
    exp_dones++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_inputs"}, int'({input1, input2}), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    chk({tag, "_fail_valid"}, int'(fail_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    launch(3, TT_OR, 0, 1'b1, 0, 1'b0, 2'b00);
    wait_done();
    repeat (3) @(negedge clk);
    chk("pass_held", int'(pass), 1);

    launch(1, TT_OR, 1, 1'b0, 2, 1'b1, 2'b01);
    wait_done();

    launch(0, TT_OR, 0, 1'b1, 0, 1'b0, 2'b00);
    wait_done();

    launch(2, TT_OR, 0, 1'b1, 0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    start     = 1'b1;
    expect_tt = 4'b0000;
    dwell     = DW'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    launch(2, 4'b0000, 1, 1'b0, 1, 1'b1, 2'b11);
    wait_done();

    launch(2, 4'b1111, 2, 1'b0, 3, 1'b1, 2'b00);
    repeat (3) @(negedge clk);
    chk("pre_reset_vec", int'({input1, input2}), 1);
    reset = 1'b1;
    q.delete();
    exp_dones--;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    launch(1, TT_OR, 0, 1'b1, 0, 1'b0, 2'b00);
    wait_done();

    launch(1, 4'b1111, 2, 1'b0, 3, 1'b1, 2'b00);
    wait_done();

    chk("done_count", dones, exp_dones);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
